// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: drains an upstream FIFO with a one-cycle read latency into a
// small local buffer and hands words downstream over valid/ready. Counts
// delivered words and supports an orderly drain when rd_en drops.
// Optional build macro FIFO_RD_PARITY_CHK_EN enables a sticky even-parity
// check on every captured word (MSB is the parity bit).
module fifo_rd_ctrl #(
    parameter int DATA_W = 6,
    parameter int BUF_AW = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              RESET_L,
    input  logic              rd_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy,
    output logic              err_parity
);

    localparam int DEPTH = 2 ** BUF_AW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [BUF_AW:0]   count;
    logic [BUF_AW-1:0] wr_ptr, rd_ptr;
    logic              vld_p1;     // a read was issued last cycle; its word is on fifo_data now
    logic [DATA_W-1:0] buf_mem [DEPTH];
    logic              push, pop;
    logic [BUF_AW+1:0] occupancy;  // buffered words plus the one in flight

    assign push      = vld_p1;
    assign pop       = valid_out & ready_in;
    assign occupancy = {1'b0, count} + {{(BUF_AW+1){1'b0}}, vld_p1};

    // State register
    always_ff @(posedge clk) begin
        if (!RESET_L) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; DRAIN only retires once nothing is in flight or buffered
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_en) state_nxt = RUN;
            RUN:     if (!rd_en) state_nxt = DRAIN;
            DRAIN: begin
                if (rd_en)                           state_nxt = RUN;
                else if (!vld_p1 && count == '0)     state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: reads only from registered state so ready_in never reaches fifo_rd
    always_comb begin
        busy      = (state != IDLE);
        fifo_rd   = RESET_L && (state == RUN) && !fifo_empty
                    && (occupancy < (BUF_AW+2)'(DEPTH));
        valid_out = (count != '0);
        data_out  = valid_out ? buf_mem[rd_ptr] : '0;
    end

    // Control state: in-flight flag, occupancy, pointers and delivered-word count
    always_ff @(posedge clk) begin
        if (!RESET_L) begin
            vld_p1   <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_cnt <= '0;
        end else begin
            vld_p1 <= fifo_rd;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // Capture stage: the word read last cycle lands in the buffer
    always_ff @(posedge clk) begin
        if (push) buf_mem[wr_ptr] <= fifo_data;
    end

`ifdef FIFO_RD_PARITY_CHK_EN
    function automatic logic parity_bad(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction

    // Sticky parity error, set by any captured word with odd overall parity
    always_ff @(posedge clk) begin
        if (!RESET_L)                         err_parity <= 1'b0;
        else if (push && parity_bad(fifo_data)) err_parity <= 1'b1;
    end
`else
    assign err_parity = 1'b0;
`endif

`ifndef SYNTHESIS
    // Read issue reserves a slot, so a capture never finds the buffer full
    always_ff @(posedge clk) begin
        if (RESET_L && push)
            assert (count < (BUF_AW+1)'(DEPTH))
            else $error("fifo_rd_ctrl: local buffer overflow");
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Testbench for fifo_rd_ctrl: behavioural FIFO with one-cycle read latency,
// scoreboard of expected words in load order.
module tb_fifo_rd_ctrl;

    localparam int DATA_W = 6;
    localparam int CNT_W  = 8;
`ifdef FIFO_RD_PARITY_CHK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              RESET_L;
    logic              rd_en;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd;
    logic              ready_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [CNT_W-1:0]  word_cnt;
    logic              busy;
    logic              err_parity;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    fifo_rd_ctrl #(.DATA_W(DATA_W), .BUF_AW(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .RESET_L(RESET_L), .rd_en(rd_en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .ready_in(ready_in),
        .data_out(data_out), .valid_out(valid_out), .word_cnt(word_cnt),
        .busy(busy), .err_parity(err_parity)
    );

    always #5 clk = ~clk;

    // One clock: sample DUT just before the edge, then model the FIFO read latency
    task automatic cyc(output logic v, output logic [DATA_W-1:0] d,
                       output logic rd, output logic err);
        #1;
        v = valid_out; d = data_out; rd = fifo_rd; err = err_parity;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        else                         fifo_data = DATA_W'($urandom);
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic load(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic test_reset();
        RESET_L = 1'b0; rd_en = 1'b1; ready_in = 1'b1;
        fifo_q.push_back(6'b111111); fifo_empty = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (fifo_rd !== 1'b0) $display("FAIL reset_fifo_rd: got %b want 0", fifo_rd); else passes++;
            checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out); else passes++;
            checks++; if (word_cnt !== '0) $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); else passes++;
            checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
            @(posedge clk); #1;
        end
        fifo_q.delete(); fifo_empty = 1'b1; rd_en = 1'b0; RESET_L = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passes++;
        checks++; if (data_out !== '0) $display("FAIL idle_data: got %0h want 0", data_out); else passes++;
    endtask

    task automatic test_single();
        logic v, rd, err; logic [DATA_W-1:0] d, e;
        int n_rd = 0, n_acc = 0;
        load(6'b010010); rd_en = 1'b1; ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(v, d, rd, err);
            if (rd) n_rd++;
            if (v) begin
                n_acc++; checks++;
                if (exp_q.size() == 0) $display("FAIL single_extra: got %0h want none", d);
                else begin e = exp_q.pop_front(); if (d !== e) $display("FAIL single_data: got %0h want %0h", d, e); else passes++; end
            end
        end
        #1;
        checks++; if (n_rd != 1) $display("FAIL single_reads: got %0d want 1", n_rd); else passes++;
        checks++; if (n_acc != 1) $display("FAIL single_valid_cycles: got %0d want 1", n_acc); else passes++;
        checks++; if (word_cnt !== 8'd1) $display("FAIL single_word_cnt: got %0d want 1", word_cnt); else passes++;
        checks++; if (busy !== 1'b1 || fifo_rd !== 1'b0) $display("FAIL single_run_idle: got busy=%b rd=%b want 1 0", busy, fifo_rd); else passes++;
    endtask

    task automatic test_burst();
        logic v, rd, err; logic [DATA_W-1:0] d, e;
        int n_acc = 0, first = -1, last = -1;
        load(6'b100100); load(6'b110110); load(6'b010100); load(6'b110000);
        ready_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(v, d, rd, err);
            if (v) begin
                n_acc++; if (first < 0) first = i; last = i; checks++;
                if (exp_q.size() == 0) $display("FAIL burst_extra: got %0h want none", d);
                else begin e = exp_q.pop_front(); if (d !== e) $display("FAIL burst_data: got %0h want %0h", d, e); else passes++; end
            end
        end
        checks++; if (n_acc != 4 || last - first != 3) $display("FAIL burst_consecutive: got %0d words over %0d cycles want 4 over 4", n_acc, last - first + 1); else passes++;
        checks++; if (word_cnt !== 8'd5) $display("FAIL burst_word_cnt: got %0d want 5", word_cnt); else passes++;
    endtask

    task automatic test_back_pressure();
        logic v, rd, err; logic [DATA_W-1:0] d, e;
        int n_rd = 0, n_acc = 0;
        load(6'b100100); load(6'b110110); load(6'b010100); load(6'b110000); load(6'b001011);
        ready_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(v, d, rd, err);
            if (rd) n_rd++;
            if (v) begin
                checks++; if (d !== 6'b100100) $display("FAIL bp_hold: got %0h want 24", d); else passes++;
            end
        end
        #1;
        checks++; if (n_rd != 4) $display("FAIL bp_reads_stop: got %0d want 4", n_rd); else passes++;
        checks++; if (fifo_rd !== 1'b0 || valid_out !== 1'b1) $display("FAIL bp_full: got rd=%b valid=%b want 0 1", fifo_rd, valid_out); else passes++;
        ready_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(v, d, rd, err);
            if (v) begin
                n_acc++; checks++;
                if (exp_q.size() == 0) $display("FAIL bp_extra: got %0h want none", d);
                else begin e = exp_q.pop_front(); if (d !== e) $display("FAIL bp_data: got %0h want %0h", d, e); else passes++; end
            end
        end
        checks++; if (n_acc != 5) $display("FAIL bp_delivered: got %0d want 5", n_acc); else passes++;
        checks++; if (word_cnt !== 8'd10) $display("FAIL bp_word_cnt: got %0d want 10", word_cnt); else passes++;
    endtask

    task automatic test_drain_and_reset();
        logic v, rd, err; logic [DATA_W-1:0] d, e;
        logic found = 1'b0;
        int n_rd = 0, n_acc = 0;
        load(6'b101010); load(6'b011001);
        rd_en = 1'b1; ready_in = 1'b1;
        for (int i = 0; i < 6 && !found; i++) begin
            #1; if (fifo_rd) begin rd_en = 1'b0; found = 1'b1; end
            cyc(v, d, rd, err);
        end
        checks++; if (!found) $display("FAIL drain_issue: got no read want one"); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL drain_busy: got %b want 1", busy); else passes++;
        for (int i = 0; i < 8; i++) begin
            cyc(v, d, rd, err);
            if (rd) n_rd++;
            if (v) begin
                n_acc++; checks++;
                if (exp_q.size() == 0) $display("FAIL drain_extra: got %0h want none", d);
                else begin e = exp_q.pop_front(); if (d !== e) $display("FAIL drain_data: got %0h want %0h", d, e); else passes++; end
            end
        end
        checks++; if (n_rd != 0) $display("FAIL drain_new_reads: got %0d want 0", n_rd); else passes++;
        checks++; if (n_acc != 1) $display("FAIL drain_delivered: got %0d want 1", n_acc); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL drain_idle: got busy=%b want 0", busy); else passes++;
        checks++; if (word_cnt !== 8'd11) $display("FAIL drain_word_cnt: got %0d want 11", word_cnt); else passes++;
        // restart with more words queued, then reset in the middle of the burst
        load(6'b000111); load(6'b111000); load(6'b010101);
        rd_en = 1'b1; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(v, d, rd, err);
            if (v) begin
                found = 1'b1; checks++;
                if (exp_q.size() == 0) $display("FAIL midrst_extra: got %0h want none", d);
                else begin e = exp_q.pop_front(); if (d !== e) $display("FAIL midrst_data: got %0h want %0h", d, e); else passes++; end
            end
        end
        checks++; if (!found) $display("FAIL midrst_start: got no word want one"); else passes++;
        RESET_L = 1'b0;
        cyc(v, d, rd, err);
        checks++; if (valid_out !== 1'b0 || data_out !== '0) $display("FAIL midrst_valid: got valid=%b data=%0h want 0 0", valid_out, data_out); else passes++;
        checks++; if (word_cnt !== '0) $display("FAIL midrst_word_cnt: got %0d want 0", word_cnt); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passes++;
        fifo_q.delete(); exp_q.delete(); fifo_empty = 1'b1; rd_en = 1'b0; RESET_L = 1'b1;
        cyc(v, d, rd, err);
    endtask

    task automatic test_parity();
        logic v, rd, err; logic [DATA_W-1:0] d, e;
        int n_acc = 0;
        load(6'b100001); load(6'b000001);
        rd_en = 1'b1; ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(v, d, rd, err);
            if (v) begin
                checks++;
                if (exp_q.size() == 0) $display("FAIL par_extra: got %0h want none", d);
                else begin e = exp_q.pop_front(); if (d !== e) $display("FAIL par_data: got %0h want %0h", d, e); else passes++; end
                checks++;
                if (n_acc == 0) begin
                    if (err !== 1'b0) $display("FAIL par_good_word: got %b want 0", err); else passes++;
                end else begin
                    if (err !== PAR_EN) $display("FAIL par_bad_word: got %b want %b", err, PAR_EN); else passes++;
                end
                n_acc++;
            end
        end
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) cyc(v, d, rd, err);
        checks++; if (n_acc != 2) $display("FAIL par_delivered: got %0d want 2", n_acc); else passes++;
        checks++; if (err_parity !== PAR_EN) $display("FAIL par_sticky: got %b want %b", err_parity, PAR_EN); else passes++;
        RESET_L = 1'b0;
        cyc(v, d, rd, err);
        checks++; if (err_parity !== 1'b0) $display("FAIL par_reset: got %b want 0", err_parity); else passes++;
        RESET_L = 1'b1;
    endtask

    initial begin
        RESET_L = 1'b0; rd_en = 1'b0; ready_in = 1'b0;
        fifo_empty = 1'b1; fifo_data = '0;
        test_reset();
        test_single();
        test_burst();
        test_back_pressure();
        test_drain_and_reset();
        test_parity();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
